// File: rtl/lifo_stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// LIFO_STACK_WATERMARK_EN adds the max_count high-water output.
package lifo_stack_pkg;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_e;

    // Bits needed to hold 0..depth inclusive.
    function automatic int unsigned clog2_cnt(input int unsigned depth);
        int unsigned n;
        n = 0;
        while ((64'(1) << n) < (64'(depth) + 64'd1)) n = n + 1;
        return n;
    endfunction

    // Push+pop on an empty stack degrades to a plain push.
    function automatic op_e decode_op(input logic push, input logic pop,
                                      input logic empty, input logic full);
        op_e op;
        op = OP_NONE;
        if (push && pop)
            op = empty ? OP_PUSH : OP_REPLACE;
        else if (push && !full)
            op = OP_PUSH;
        else if (pop && !empty)
            op = OP_POP;
        return op;
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Request/status bundle between a stack user (master) and lifo_stack (slave).
// max_count exists only when LIFO_STACK_WATERMARK_EN is defined.
interface lifo_stack_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = lifo_stack_pkg::clog2_cnt(DEPTH);

    logic             push;
    logic             pop;
    logic             flush;
    logic             clr_err;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [WIDTH-1:0] top_data;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
`ifdef LIFO_STACK_WATERMARK_EN
    logic [CW-1:0]    max_count;
`endif

    modport master (
        output push, pop, flush, clr_err, push_data,
        input  pop_data, pop_valid, top_data, count, empty, full,
               overflow, underflow
`ifdef LIFO_STACK_WATERMARK_EN
        , input max_count
`endif
    );

    modport slave (
        input  push, pop, flush, clr_err, push_data,
        output pop_data, pop_valid, top_data, count, empty, full,
               overflow, underflow
`ifdef LIFO_STACK_WATERMARK_EN
        , output max_count
`endif
    );

endinterface

// File: rtl/lifo_stack_mem.sv
// DEPTH x WIDTH stack storage: one synchronous write port, two
// combinational read ports, no reset on the array.
module lifo_stack_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rd1_addr,
    output logic [WIDTH-1:0] rd1_data,
    input  logic [AW-1:0]    rd2_addr,
    output logic [WIDTH-1:0] rd2_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Indices past DEPTH only occur for non-power-of-two depths on unused reads.
    assign rd1_data = (32'(rd1_addr) < DEPTH) ? mem[rd1_addr] : '0;
    assign rd2_data = (32'(rd2_addr) < DEPTH) ? mem[rd2_addr] : '0;

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack: registered top/pop data, replace, flush, sticky errors.
// Define LIFO_STACK_WATERMARK_EN to add the max_count high-water register.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    lifo_stack_if.slave bus
);
    localparam int unsigned CW = clog2_cnt(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty_c, full_c;
    op_e              op_c;
    logic             we_c;
    logic [AW-1:0]    waddr_c;
    logic [WIDTH-1:0] rd1_c, rd2_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CW'(DEPTH));
    assign op_c    = decode_op(bus.push, bus.pop, empty_c, full_c);

    lifo_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk      (clk),
        .we       (we_c),
        .waddr    (waddr_c),
        .wdata    (bus.push_data),
        .rd1_addr (AW'(count_q - CW'(1))),
        .rd1_data (rd1_c),
        .rd2_addr (AW'(count_q - CW'(2))),
        .rd2_data (rd2_c)
    );

    // Next-state: flush overrides push/pop; clr_err loses to a same-cycle error.
    always_comb begin
        count_d     = count_q;
        top_d       = top_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q & ~bus.clr_err;
        unf_d       = unf_q & ~bus.clr_err;
        we_c        = 1'b0;
        waddr_c     = AW'(count_q);
        if (bus.flush) begin
            count_d = '0;
            top_d   = '0;
        end else begin
            if (bus.push && !bus.pop && full_c) ovf_d = 1'b1;
            if (bus.pop && empty_c)             unf_d = 1'b1;
            // rd1 (mem[count-1]) always equals top_q while the stack is non-empty.
            case (op_c)
                OP_PUSH: begin
                    we_c    = 1'b1;
                    waddr_c = AW'(count_q);
                    count_d = count_q + CW'(1);
                    top_d   = bus.push_data;
                end
                OP_POP: begin
                    count_d     = count_q - CW'(1);
                    pop_data_d  = rd1_c;
                    pop_valid_d = 1'b1;
                    top_d       = (count_q >= CW'(2)) ? rd2_c : '0;
                end
                OP_REPLACE: begin
                    we_c        = 1'b1;
                    waddr_c     = AW'(count_q - CW'(1));
                    pop_data_d  = rd1_c;
                    pop_valid_d = 1'b1;
                    top_d       = bus.push_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            top_q       <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            top_q       <= top_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.top_data  = top_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.empty     = empty_c;
    assign bus.full      = full_c;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

`ifdef LIFO_STACK_WATERMARK_EN
    logic [CW-1:0] max_q;

    // High-water mark tracks count_d so it moves on the same edge as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  max_q <= '0;
        else if (count_d > max_q) max_q <= count_d;
    end

    assign bus.max_count = max_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (WIDTH=32, DEPTH=16).
// Covers LIFO order, full/empty boundaries, replace, flush, sticky errors, async reset.
module tb_lifo_stack;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of request inputs, then return them to idle.
    task automatic cyc(input logic p, input logic po, input logic [31:0] d,
                       input logic fl = 1'b0, input logic ce = 1'b0);
        bus.push      = p;
        bus.pop       = po;
        bus.push_data = d;
        bus.flush     = fl;
        bus.clr_err   = ce;
        tick();
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
        bus.push_data = '0;
        tick();
        tick();
        check("rst_count",     32'(bus.count), 32'd0);
        check("rst_empty",     32'(bus.empty), 32'd1);
        check("rst_full",      32'(bus.full), 32'd0);
        check("rst_top",       bus.top_data, 32'h0);
        check("rst_pop_data",  bus.pop_data, 32'h0);
        check("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        check("rst_ovf",       32'(bus.overflow), 32'd0);
        check("rst_unf",       32'(bus.underflow), 32'd0);
        rst = 1'b0;
        tick();

        // LIFO order
        cyc(1'b1, 1'b0, 32'hA1);
        cyc(1'b1, 1'b0, 32'hB2);
        cyc(1'b1, 1'b0, 32'hC3);
        check("push3_count", 32'(bus.count), 32'd3);
        check("push3_top",   bus.top_data, 32'hC3);
        check("push3_pv",    32'(bus.pop_valid), 32'd0);
        cyc(1'b0, 1'b1, 32'h0);
        check("pop1_data",  bus.pop_data, 32'hC3);
        check("pop1_valid", 32'(bus.pop_valid), 32'd1);
        check("pop1_top",   bus.top_data, 32'hB2);
        check("pop1_count", 32'(bus.count), 32'd2);
        cyc(1'b0, 1'b1, 32'h0);
        check("pop2_data", bus.pop_data, 32'hB2);
        check("pop2_top",  bus.top_data, 32'hA1);
        cyc(1'b0, 1'b1, 32'h0);
        check("pop3_data",  bus.pop_data, 32'hA1);
        check("pop3_valid", 32'(bus.pop_valid), 32'd1);
        check("pop3_top",   bus.top_data, 32'h0);
        check("pop3_empty", 32'(bus.empty), 32'd1);
        tick();
        check("idle_pv",   32'(bus.pop_valid), 32'd0);
        check("idle_hold", bus.pop_data, 32'hA1);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'h100 + 32'(i));
        check("fill_full",  32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_top",   bus.top_data, 32'h10F);
        check("fill_ovf",   32'(bus.overflow), 32'd0);
        cyc(1'b1, 1'b0, 32'hFF);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd16);
        check("ovf_top",   bus.top_data, 32'h10F);
        check("ovf_full",  32'(bus.full), 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("clr_ovf", 32'(bus.overflow), 32'd0);
        // Replace while full
        cyc(1'b1, 1'b1, 32'h77);
        check("repfull_pop",   bus.pop_data, 32'h10F);
        check("repfull_top",   bus.top_data, 32'h77);
        check("repfull_count", 32'(bus.count), 32'd16);
        check("repfull_ovf",   32'(bus.overflow), 32'd0);
        cyc(1'b0, 1'b1, 32'h0);
        check("poprep_data", bus.pop_data, 32'h77);
        check("poprep_top",  bus.top_data, 32'h10E);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_top",   bus.top_data, 32'h0);

        // Pop on empty
        cyc(1'b0, 1'b1, 32'h0);
        check("unf_flag",  32'(bus.underflow), 32'd1);
        check("unf_pv",    32'(bus.pop_valid), 32'd0);
        check("unf_count", 32'(bus.count), 32'd0);
        check("unf_hold",  bus.pop_data, 32'h77);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("clr_unf", 32'(bus.underflow), 32'd0);

        // Replace with one entry
        cyc(1'b1, 1'b0, 32'h55);
        cyc(1'b1, 1'b1, 32'h77);
        check("rep_pop",   bus.pop_data, 32'h55);
        check("rep_pv",    32'(bus.pop_valid), 32'd1);
        check("rep_top",   bus.top_data, 32'h77);
        check("rep_count", 32'(bus.count), 32'd1);
        cyc(1'b0, 1'b1, 32'h0);
        check("rep_pop2", bus.pop_data, 32'h77);
        check("rep_empty", 32'(bus.empty), 32'd1);

        // Push+pop on empty acts as push and flags underflow
        cyc(1'b1, 1'b1, 32'h11);
        check("pp_empty_count", 32'(bus.count), 32'd1);
        check("pp_empty_top",   bus.top_data, 32'h11);
        check("pp_empty_unf",   32'(bus.underflow), 32'd1);
        check("pp_empty_pv",    32'(bus.pop_valid), 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("clrfl_unf",   32'(bus.underflow), 32'd0);
        check("clrfl_count", 32'(bus.count), 32'd0);
        // New error beats clr_err in the same cycle
        cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        check("setwins_unf", 32'(bus.underflow), 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Flush with simultaneous push
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h200 + 32'(i));
        check("five_count", 32'(bus.count), 32'd5);
        cyc(1'b1, 1'b0, 32'h3FF, 1'b1);
        check("flpush_count", 32'(bus.count), 32'd0);
        check("flpush_empty", 32'(bus.empty), 32'd1);
        check("flpush_ovf",   32'(bus.overflow), 32'd0);
        check("flpush_unf",   32'(bus.underflow), 32'd0);

        // Async reset between edges
        cyc(1'b1, 1'b0, 32'hE1);
        cyc(1'b1, 1'b0, 32'hE2);
        cyc(1'b0, 1'b1, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_top",   bus.top_data, 32'h0);
        check("arst_pd",    bus.pop_data, 32'h0);
        check("arst_pv",    32'(bus.pop_valid), 32'd0);
        check("arst_empty", 32'(bus.empty), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Watermark sequence: push 7, pop 4, push 2
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 32'h20 + 32'(i));
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h0);
        check("wm_mid_top", bus.top_data, 32'h22);
        cyc(1'b1, 1'b0, 32'h30);
        cyc(1'b1, 1'b0, 32'h31);
        check("wm_count", 32'(bus.count), 32'd5);
        check("wm_top",   bus.top_data, 32'h31);
`ifdef LIFO_STACK_WATERMARK_EN
        check("wm_max", 32'(bus.max_count), 32'd7);
`endif
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("wm_flush_count", 32'(bus.count), 32'd0);
`ifdef LIFO_STACK_WATERMARK_EN
        check("wm_flush_max", 32'(bus.max_count), 32'd7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised hardware LIFO stack for the datapath: call/return addresses, operand spill, nested-context save.
- Generalises the earlier fixed 32x16 stack:
  - configurable width and depth;
  - asynchronous reset;
  - full/empty/count status;
  - registered top-of-stack peek;
  - simultaneous push+pop (replace top);
  - flush;
  - sticky overflow/underflow error flags.

Parameters:
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 16, number of entries (>=2, any value, not restricted to power of two)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- push  in  1  push request, sampled at posedge clk
- pop  in  1  pop request, sampled at posedge clk
- flush  in  1  synchronous clear of stack contents (sp to 0)
- clr_err  in  1  synchronous clear of sticky error flags
- push_data  in  WIDTH  word to push
- pop_data  out  WIDTH  registered word removed by last accepted pop
- pop_valid  out  1  one-cycle pulse: pop_data updated this cycle
- top_data  out  WIDTH  registered current top of stack (0 when empty)
- count  out  CW  current number of entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: push rejected while full
- underflow  out  1  sticky: pop rejected while empty

Behaviour:
- Reset (async, rst=1): count=0, pop_data=0, pop_valid=0, top_data=0, overflow=0, underflow=0, empty=1, full=0. Memory contents are not reset.
- empty/full are decoded directly from the count register. No extra latency.
- All operations resolve at posedge clk. State is visible the cycle after the edge.
- Priority: rst > flush > push/pop.
  - flush: count<=0, top_data<=0, pop_valid<=0. push/pop in the same cycle are ignored and raise no errors.
- push only, not full: mem[count]<=push_data, count+1, top_data<=push_data.
- push only, full: no state change, overflow<=1.
- pop only, not empty:
  - count-1, pop_data<=top_data, pop_valid<=1;
  - top_data<=mem[count-2] if count>=2, else 0.
- pop only, empty: no state change, pop_valid<=0, underflow<=1.
- push+pop, not empty (including full): replace.
  - pop_data<=top_data, pop_valid<=1;
  - mem[count-1]<=push_data, top_data<=push_data;
  - count unchanged, no errors.
- push+pop, empty: treated as push only (count becomes 1, top_data=push_data). underflow<=1, pop_valid<=0.
- pop_valid is 0 in any cycle without an accepted pop.
- pop_data holds its last value until the next accepted pop.
- clr_err clears overflow/underflow. If a new error occurs in the same cycle, set wins.
- Memory read for top refresh is combinational from the array into the top_data register. Pop-to-top latency is one cycle.
- count arithmetic is CW bits wide. It never wraps because guards prevent it.

Optional Feature:
- LIFO_STACK_WATERMARK_EN defined:
  - adds output max_count [CW] = highest count reached since reset;
  - updated on the same edge as count;
  - cleared by rst only (not by flush or clr_err).
- Undefined: port and register are absent. All other behaviour is identical.

Decomposition:
- Package lifo_stack_pkg contains:
  - op enum: OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, decoded from {push,pop,empty,full};
  - function clog2_cnt(depth) for CW.
- One sub-module, lifo_stack_mem: DEPTH x WIDTH storage with one synchronous write port and two combinational read ports (index count-1 and count-2), no reset.
- Control, count, flags and top register stay in lifo_stack.

Test Plan:
- Reset then push 0xA1,0xB2,0xC3 -> count=3, top_data=0xC3. Then 3 pops -> pop_data 0xC3,0xB2,0xA1 with pop_valid pulses, empty=1, top_data=0.
- Fill DEPTH=16, then push 0xFF -> full=1, count=16, overflow=1, top unchanged. clr_err -> overflow=0.
- Pop on empty -> underflow=1, pop_valid=0, count=0.
- Push+pop together:
  - with top=0x55, push_data=0x77 -> pop_data=0x55, top_data=0x77, count unchanged;
  - on empty with 0x11 -> count=1, top=0x11, underflow=1.
- Push 5 words, flush with simultaneous push -> count=0, empty=1, no error. Assert rst mid-sequence (between edges) -> outputs 0 immediately.
- With LIFO_STACK_WATERMARK_EN: push 7, pop 4, push 2 -> max_count=7, count=5. Flush -> max_count stays 7.
